// File: rtl/imem_rom.sv
// ============================================================================
// Module  : imem_rom
// Brief   : 64-word fixed instruction ROM with registered, width-adapted read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_rom #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   addr,
    output logic [N-1:0] q
);

    localparam int c_WORD_W = 32;

    logic [c_WORD_W-1:0] w_word;
    logic [N-1:0]        w_data;
    logic [N-1:0]        r_q;

    // Only the first eight words hold a program; the rest of the table reads as zero.
    always_comb begin
        w_word = 32'h0000_0000;
        case (addr)
            6'd0:    w_word = 32'hF840_0001;
            6'd1:    w_word = 32'hF840_8002;
            6'd2:    w_word = 32'h8B02_0023;
            6'd3:    w_word = 32'hCB02_0024;
            6'd4:    w_word = 32'h8A02_0025;
            6'd5:    w_word = 32'hAA02_0026;
            6'd6:    w_word = 32'hF801_0003;
            6'd7:    w_word = 32'hB400_001F;
            default: w_word = 32'h0000_0000;
        endcase
    end

    generate
        if (N < c_WORD_W) begin : g_trunc
            assign w_data = w_word[N-1:0];
        end else if (N == c_WORD_W) begin : g_exact
            assign w_data = w_word;
        end else begin : g_zext
            assign w_data = {{(N-c_WORD_W){1'b0}}, w_word};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_data;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_rom.sv
// ============================================================================
// Module  : tb_imem_rom
// Brief   : Directed vector bench for imem_rom at N=32, N=16 and N=64.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_rom;

    logic        clk;
    logic        reset;
    logic [5:0]  addr;
    logic [31:0] q32;
    logic [15:0] q16;
    logic [63:0] q64;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic [5:0]  a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    imem_rom #(.N(32)) u_dut32 (.clk(clk), .reset(reset), .addr(addr), .q(q32));
    imem_rom #(.N(16)) u_dut16 (.clk(clk), .reset(reset), .addr(addr), .q(q16));
    imem_rom #(.N(64)) u_dut64 (.clk(clk), .reset(reset), .addr(addr), .q(q64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input logic [5:0] a);
        case (a)
            6'd0:    return 32'hF8400001;
            6'd1:    return 32'hF8408002;
            6'd2:    return 32'h8B020023;
            6'd3:    return 32'hCB020024;
            6'd4:    return 32'h8A020025;
            6'd5:    return 32'hAA020026;
            6'd6:    return 32'hF8010003;
            6'd7:    return 32'hB400001F;
            default: return 32'h00000000;
        endcase
    endfunction

    // Drive on the falling edge, then look at q just after the next rising edge.
    task automatic step(input logic r, input logic [5:0] a);
        @(negedge clk);
        reset = r;
        addr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [31:0] exp);
        logic [15:0] e16;
        logic [63:0] e64;
        e16 = exp[15:0];
        e64 = {32'h0, exp};
        n_vec++;
        if (q32 !== exp) begin
            n_err++;
            $display("FAIL %s N=32: got %h expected %h", name, q32, exp);
        end
        n_vec++;
        if (q16 !== e16) begin
            n_err++;
            $display("FAIL %s N=16: got %h expected %h", name, q16, e16);
        end
        n_vec++;
        if (q64 !== e64) begin
            n_err++;
            $display("FAIL %s N=64: got %h expected %h", name, q64, e64);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        addr  = 6'd0;

        vecs[0]  = '{1'b1, 6'd2,  32'h00000000};
        vecs[1]  = '{1'b1, 6'd2,  32'h00000000};
        vecs[2]  = '{1'b0, 6'd2,  32'h8B020023};
        vecs[3]  = '{1'b0, 6'd0,  32'hF8400001};
        vecs[4]  = '{1'b0, 6'd6,  32'hF8010003};
        vecs[5]  = '{1'b0, 6'd7,  32'hB400001F};
        vecs[6]  = '{1'b0, 6'd1,  32'hF8408002};
        vecs[7]  = '{1'b0, 6'd63, 32'h00000000};
        vecs[8]  = '{1'b0, 6'd0,  32'hF8400001};
        vecs[9]  = '{1'b0, 6'd8,  32'h00000000};
        vecs[10] = '{1'b0, 6'd4,  32'h8A020025};
        vecs[11] = '{1'b0, 6'd3,  32'hCB020024};
        vecs[12] = '{1'b0, 6'd3,  32'hCB020024};
        vecs[13] = '{1'b0, 6'd3,  32'hCB020024};
        vecs[14] = '{1'b0, 6'd3,  32'hCB020024};
        vecs[15] = '{1'b0, 6'd3,  32'hCB020024};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].a);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full sweep; q after each edge reflects the address driven before it.
        for (int a = 0; a < 64; a++) begin
            step(1'b0, 6'(a));
            check_all($sformatf("sweep%0d", a), ref_word(6'(a)));
        end

        // Reset in mid-sweep wins over the read, then reads resume on the next edge.
        step(1'b0, 6'd2);
        check_all("mid_pre", 32'h8B020023);
        step(1'b0, 6'd3);
        check_all("mid_pre2", 32'hCB020024);
        step(1'b1, 6'd4);
        check_all("mid_reset", 32'h00000000);
        step(1'b0, 6'd5);
        check_all("mid_release", 32'hAA020026);

        // Wrap 63 -> 0 on consecutive cycles.
        step(1'b0, 6'd63);
        check_all("wrap63", 32'h00000000);
        step(1'b0, 6'd0);
        check_all("wrap0", 32'hF8400001);

        // Holding an address across edges keeps q stable.
        step(1'b0, 6'd7);
        check_all("hold7a", 32'hB400001F);
        step(1'b0, 6'd7);
        check_all("hold7b", 32'hB400001F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
